psram_arbiter: RTL
==================

Name: psram_arbiter

Overview:
Two-requester arbiter and cycle sequencer for the Nexys3 asynchronous cellular RAM (PSRAM). Up to two client blocks, e.g. a display fetch path and a host/write path, share the single RAM bus through this block. It grants one request at a time using round-robin arbitration. For the granted request it runs a timed asynchronous read or write cycle on the MemAdr/MemDB/strobe pins and returns read data with a done pulse. It replaces ad-hoc strobe generation in top levels that need more than one RAM client.

Parameters:
WAIT_CYCLES, 6, number of clk cycles the access strobe (MemOE or MemWR) is held low; 1..15; 6 at 100 MHz meets the 70 ns PSRAM access time.
ADDR_W, 23, RAM word address width.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0, req1  input  1 each  request from client 0 / 1; level, held until gnt.
we0, we1  input  1 each  1 = write, 0 = read; sampled at grant.
addr0, addr1  input  ADDR_W each  word address; sampled at grant.
wdata0, wdata1  input  16 each  write data; sampled at grant.
be0, be1  input  2 each  byte enables, bit1 = upper byte, bit0 = lower byte; active high.
gnt0, gnt1  output  1 each  one-cycle pulse: request accepted and fields latched.
done0, done1  output  1 each  one-cycle pulse: cycle complete; rdata valid for reads.
rdata  output  16  last read data, held until the next read completes.
busy  output  1  high whenever state != IDLE.
MemAdr  output  ADDR_W  RAM address.
MemDB  inout  16  RAM data bus; driven only during write ACCESS/HOLD, else high-Z.
RamCLK  output  1  constant 0 (asynchronous mode).
RamCS, MemOE, MemWR, RamLB, RamUB  output  1 each  active-low RAM controls.

Behaviour:
- All outputs registered except MemDB, whose enable comes from a registered write-drive flag.
- Reset values, applied asynchronously on rst_n low:
  - State IDLE; RamCS, MemOE, MemWR, RamLB, RamUB all 1; RamCLK 0.
  - MemAdr 0; MemDB high-Z; gnt*/done*/busy 0; rdata 0.
  - Round-robin pointer set so client 0 wins the first contention.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE: if any req is high, pick the winner.
  - Only one requesting: that one wins.
  - Both requesting: the client not granted last wins.
  - On the winning edge: pulse gnt for the winner, latch its we/addr/wdata/be, update the pointer, go to SETUP.
- SETUP, 1 cycle: MemAdr = latched addr; RamCS = 0; RamLB = ~be[0]; RamUB = ~be[1]; MemOE = MemWR = 1.
  - For a write, MemDB is driven with the latched wdata from this cycle onward.
- ACCESS, exactly WAIT_CYCLES cycles, tracked by a 4-bit counter cleared on entry:
  - Read: MemOE = 0. Write: MemWR = 0.
  - RamCS, byte enables and address are held.
  - Read: rdata captures MemDB at the clock edge that ends the final ACCESS cycle.
- HOLD, 1 cycle:
  - MemOE = MemWR = 1 and RamCS = 1.
  - Address is held; write data stays driven (hold time).
  - Pulse done for the granted client.
  - Next state is IDLE; MemDB returns to high-Z.
- Throughput:
  - Grant-to-done latency = WAIT_CYCLES + 2 cycles.
  - Minimum spacing between consecutive grants = WAIT_CYCLES + 3 cycles.
  - Requests are never accepted outside IDLE. A req held high through done is re-arbitrated in the next IDLE cycle.
- be = 00: the full cycle still runs with RamLB = RamUB = 1 (no RAM effect) and done still pulses. For a read with be = 00, rdata is still updated from the floating bus; clients must not rely on it.
- A req dropped before gnt is simply not served; no error is raised.
- Reset mid-cycle (any state): strobes deassert and MemDB floats asynchronously; the transaction is discarded with no done pulse.
- At most one of gnt0/gnt1, one of done0/done1, and one of MemOE/MemWR is active in any cycle.

Test Plan:
1. Hold rst_n = 0 for 3 cycles, then release -> RamCS/MemOE/MemWR/RamLB/RamUB = 1, RamCLK = 0, MemDB = Z, busy = 0, rdata = 0.
2. req0 = 1, we0 = 0, addr0 = 23'h000003, be0 = 11; RAM model returns 16'hA5C3; WAIT_CYCLES = 6 -> gnt0 on the first edge; MemOE low for exactly 6 cycles; done0 8 cycles after gnt0; rdata = 16'hA5C3.
3. req1 = 1, we1 = 1, addr1 = 23'h000005, wdata1 = 16'h1234, be1 = 01 -> RamLB = 0, RamUB = 1, MemWR low for 6 cycles, MemDB = 16'h1234 from SETUP through HOLD; the model's lower byte at address 5 becomes 34h; done1 pulses.
4. req0 and req1 both held high for 3 transactions -> grant order 0, 1, 0; grants spaced 9 cycles apart; never two grants or two dones together.
5. rst_n pulled low during the third ACCESS cycle of a write -> MemWR/RamCS high and MemDB = Z immediately; no done; after release, a fresh request completes normally.
6. WAIT_CYCLES = 2 build, single read -> MemOE low for 2 cycles; done 4 cycles after gnt.

Source files
------------

// File: rtl/psram_arbiter.sv
// psram_arbiter: two-client round-robin arbiter and timed async
// read/write cycle sequencer for the Nexys3 cellular RAM (PSRAM).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   reqN, weN, addrN,     client N request (level, held until gntN),
//   wdataN, beN           direction, word address, write data, byte enables
//   gntN                  1-cycle pulse: request accepted, fields latched
//   doneN                 1-cycle pulse: cycle complete, rdata valid (reads)
//   rdata                 last read data, held until the next read completes
//   busy                  high while a cycle is in progress
//   MemAdr, MemDB         RAM address and bidirectional data bus
//   RamCLK                tied low (asynchronous mode)
//   RamCS, MemOE, MemWR,  active-low RAM chip select, output enable,
//   RamLB, RamUB          write strobe, lower/upper byte enables

module psram_arbiter #(
   parameter int WAIT_CYCLES = 6,
   parameter int ADDR_W      = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [15:0]       wdata0,
   input  logic [15:0]       wdata1,
   input  logic [1:0]        be0,
   input  logic [1:0]        be1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [15:0]       rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] MemAdr,
   inout  wire  [15:0]       MemDB,
   output logic              RamCLK,
   output logic              RamCS,
   output logic              MemOE,
   output logic              MemWR,
   output logic              RamLB,
   output logic              RamUB
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t            state, state_d;
   logic [3:0]        cnt, cnt_d;
   logic              last, last_d;
   logic              owner, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [1:0]        be_q, be_d;
   logic              drive, drive_d;

   logic              pick, act;
   logic              gnt0_d, gnt1_d;
   logic              done0_d, done1_d;
   logic              cs_d, oe_d, wr_d;
   logic              lb_d, ub_d;
   logic [ADDR_W-1:0] adr_d;
   logic [15:0]       rdata_d;

   assign RamCLK = 1'b0;
   assign MemDB  = drive ? wdata_q : 16'hzzzz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         last    <= 1'b1;
         owner   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         drive   <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         busy    <= 1'b0;
         rdata   <= '0;
         MemAdr  <= '0;
         RamCS   <= 1'b1;
         MemOE   <= 1'b1;
         MemWR   <= 1'b1;
         RamLB   <= 1'b1;
         RamUB   <= 1'b1;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         last    <= last_d;
         owner   <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         drive   <= drive_d;
         gnt0    <= gnt0_d;
         gnt1    <= gnt1_d;
         done0   <= done0_d;
         done1   <= done1_d;
         busy    <= (state_d != IDLE);
         rdata   <= rdata_d;
         MemAdr  <= adr_d;
         RamCS   <= cs_d;
         MemOE   <= oe_d;
         MemWR   <= wr_d;
         RamLB   <= lb_d;
         RamUB   <= ub_d;
      end
   end

   // Pin values are derived from the next state and next latched
   // fields so the registered pins line up with the state they belong to.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      last_d  = last;
      owner_d = owner;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      pick    = 1'b0;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      rdata_d = rdata;

      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               // last = 1 means client 1 was granted most recently
               pick    = req1 && (!req0 || !last);
               state_d = SETUP;
               owner_d = pick;
               last_d  = pick;
               we_d    = pick ? we1    : we0;
               addr_d  = pick ? addr1  : addr0;
               wdata_d = pick ? wdata1 : wdata0;
               be_d    = pick ? be1    : be0;
               gnt0_d  = !pick;
               gnt1_d  = pick;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
         end
         ACCESS: begin
            if (cnt == LAST_CNT) begin
               state_d = HOLD;
               if (!we_q)
                  rdata_d = MemDB;
            end else begin
               cnt_d = cnt + 4'd1;
            end
         end
         HOLD: begin
            state_d = IDLE;
            done0_d = !owner;
            done1_d = owner;
         end
         default: state_d = IDLE;
      endcase

      act     = (state_d != IDLE);
      cs_d    = !(state_d == SETUP || state_d == ACCESS);
      oe_d    = !(state_d == ACCESS && !we_d);
      wr_d    = !(state_d == ACCESS && we_d);
      lb_d    = act ? ~be_d[0] : 1'b1;
      ub_d    = act ? ~be_d[1] : 1'b1;
      adr_d   = act ? addr_d : MemAdr;
      drive_d = act && we_d;
   end

endmodule
